irq_pending_latch: RTL and testbench



---
 rtl/irq_pkg.sv | 27 ++
 rtl/rise_detect.sv | 55 +++++
 rtl/irq_pending_latch.sv | 74 +++++++
 tb/tb_irq_pending_latch.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared sizing, types and saturating-add helper for the interrupt pending latch.
package irq_pkg;

  localparam int unsigned N_REQ = 4;
  localparam int unsigned IDX_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = 8;

  typedef logic [N_REQ-1:0] req_t;
  typedef logic [IDX_W-1:0] idx_t;
  typedef logic [CNT_W-1:0] cnt_t;

  localparam cnt_t CntMax = '1;

  // Adds the number of set bits in drops to base, clamping at CntMax.
  function automatic cnt_t sat_add(cnt_t base, req_t drops);
    logic [CNT_W:0] sum;
    sum = {1'b0, base};
    for (int i = 0; i < int'(N_REQ); i++) begin
      sum = sum + {{CNT_W{1'b0}}, drops[i]};
    end
    if (sum > {1'b0, CntMax}) begin
      return CntMax;
    end
    return sum[CNT_W-1:0];
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a request vector; REQ_SYNC_EN adds a 2-flop synchronizer in front.
module rise_detect
  import irq_pkg::*;
#(
  parameter int unsigned Width = N_REQ
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [Width-1:0] req_i,
  output logic [Width-1:0] rise_o
);

  logic [Width-1:0] req_s;
  logic [Width-1:0] prev_d, prev_q;

`ifdef REQ_SYNC_EN
  logic [Width-1:0] sync1_d, sync1_q;
  logic [Width-1:0] sync2_d, sync2_q;

  always_comb begin
    sync1_d = req_i;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign req_s = sync2_q;
`else
  assign req_s = req_i;
`endif

  always_comb begin
    prev_d = req_s;
  end

  // prev resets low so a line held high through reset still yields an edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= '0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise_o = req_s & ~prev_q;

endmodule

// File: rtl/irq_pending_latch.sv
// Sticky, maskable interrupt pending bits with ack-by-index clear and a saturating drop counter.
// Optional REQ_SYNC_EN inserts a 2-flop request synchronizer (latency 3 instead of 1).
module irq_pending_latch
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             mask_we,
  input  logic [N_REQ-1:0] mask_in,
  input  logic             ack,
  input  logic [IDX_W-1:0] ack_idx,
  output logic [N_REQ-1:0] pending,
  output logic [N_REQ-1:0] raw_pending,
  output logic             any_pending,
  output logic [CNT_W-1:0] drop_count
);

  req_t rise;
  req_t clr;
  req_t drop;
  req_t raw_d, raw_q;
  req_t mask_d, mask_q;
  cnt_t cnt_d, cnt_q;

  rise_detect #(
    .Width(N_REQ)
  ) u_rise_detect (
    .clk   (clk),
    .rst   (rst),
    .req_i (req),
    .rise_o(rise)
  );

  // Out-of-range indices match no line and are therefore ignored.
  always_comb begin
    clr = '0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      clr[i] = ack && (ack_idx == idx_t'(i));
    end
  end

  // A set on the same edge as a clear wins and is not a drop.
  always_comb begin
    drop  = rise & raw_q & ~clr;
    raw_d = (raw_q & ~clr) | rise;
    cnt_d = sat_add(cnt_q, drop);
  end

  always_comb begin
    mask_d = mask_q;
    if (mask_we) begin
      mask_d = mask_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      raw_q  <= '0;
      mask_q <= '1;
      cnt_q  <= '0;
    end else begin
      raw_q  <= raw_d;
      mask_q <= mask_d;
      cnt_q  <= cnt_d;
    end
  end

  assign raw_pending = raw_q;
  assign pending     = raw_q & mask_q;
  assign any_pending = |(raw_q & mask_q);
  assign drop_count  = cnt_q;

endmodule

// File: tb/tb_irq_pending_latch.sv
// Directed bench for irq_pending_latch with an event-level reference model checked every cycle.
module tb_irq_pending_latch;

`ifdef REQ_SYNC_EN
  localparam int Lat = 3;
`else
  localparam int Lat = 1;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       mask_we;
  logic [3:0] mask_in;
  logic       ack;
  logic [1:0] ack_idx;
  logic [3:0] pending;
  logic [3:0] raw_pending;
  logic       any_pending;
  logic [7:0] drop_count;

  int total = 0;
  int bad   = 0;

  irq_pending_latch dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .mask_we    (mask_we),
    .mask_in    (mask_in),
    .ack        (ack),
    .ack_idx    (ack_idx),
    .pending    (pending),
    .raw_pending(raw_pending),
    .any_pending(any_pending),
    .drop_count (drop_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, exp, exp,
               $time);
    end
  endtask

  // Reference model: event bookkeeping per line, with a plain delay line for synchronizer latency.
  bit [3:0] m_raw;
  bit [3:0] m_mask;
  bit [3:0] m_prev;
  bit [3:0] m_pipe [2];
  int       m_cnt;

  always @(posedge clk) begin
    bit [3:0] eff;
    int       drops;
    if (rst) begin
      m_raw   = '0;
      m_mask  = '1;
      m_prev  = '0;
      m_pipe[0] = '0;
      m_pipe[1] = '0;
      m_cnt   = 0;
    end else begin
      eff = (Lat == 1) ? req : m_pipe[1];
      m_pipe[1] = m_pipe[0];
      m_pipe[0] = req;
      drops = 0;
      for (int i = 0; i < 4; i++) begin
        bit rose;
        bit cleared;
        rose    = eff[i] && !m_prev[i];
        cleared = ack && (int'(ack_idx) == i);
        if (rose) begin
          if (m_raw[i] && !cleared) drops++;
          m_raw[i] = 1'b1;
        end else if (cleared) begin
          m_raw[i] = 1'b0;
        end
      end
      m_cnt = (m_cnt + drops > 255) ? 255 : m_cnt + drops;
      if (mask_we) m_mask = mask_in;
      m_prev = eff;
    end
  end

  always @(negedge clk) begin
    chk("model_raw", int'(raw_pending), int'(m_raw));
    chk("model_pending", int'(pending), int'(m_raw & m_mask));
    chk("model_any", int'(any_pending), int'(|(m_raw & m_mask)));
    chk("model_drop", int'(drop_count), m_cnt);
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [3:0] v);
    req = v;
    cyc(1);
    req = '0;
    cyc(1);
  endtask

  initial begin
    rst = 1'b1; req = 4'b0100; mask_we = 1'b0; mask_in = '0; ack = 1'b0; ack_idx = '0;
    cyc(2);
    chk("rst_raw", int'(raw_pending), 'b0000);
    chk("rst_any", int'(any_pending), 0);
    chk("rst_drop", int'(drop_count), 0);

    // Line held high through reset is captured after release.
    rst = 1'b0;
    cyc(Lat);
    chk("hold_raw", int'(raw_pending), 'b0100);
    chk("hold_pending", int'(pending), 'b0100);
    chk("hold_any", int'(any_pending), 1);
    chk("hold_drop", int'(drop_count), 0);
    req = '0;
    ack = 1'b1; ack_idx = 2'd2;
    cyc(1);
    ack = 1'b0;
    chk("clr2_raw", int'(raw_pending), 'b0000);

    // Two lines pulsed, then acked one at a time.
    req = 4'b1010;
    cyc(1);
    req = '0;
    cyc(Lat - 1);
    chk("pulse_pending", int'(pending), 'b1010);
    ack = 1'b1; ack_idx = 2'd3;
    cyc(1);
    chk("ack3_pending", int'(pending), 'b0010);
    ack_idx = 2'd1;
    cyc(1);
    ack = 1'b0;
    chk("ack1_pending", int'(pending), 'b0000);
    chk("ack1_any", int'(any_pending), 0);

    // First pulse sets, next three are drops.
    for (int k = 0; k < 4; k++) pulse(4'b0001);
    cyc(Lat);
    chk("drop3_cnt", int'(drop_count), 3);
    chk("drop3_raw", int'(raw_pending), 'b0001);

    // Rise lands on the same edge as ack of that line: set wins, no drop.
    req = 4'b0001;
    if (Lat > 1) begin
      cyc(1);
      req = '0;
      cyc(Lat - 2);
    end
    ack = 1'b1; ack_idx = 2'd0;
    cyc(1);
    ack = 1'b0; req = '0;
    chk("setwin_raw", int'(raw_pending), 'b0001);
    chk("setwin_cnt", int'(drop_count), 3);
    cyc(Lat);
    ack = 1'b1; ack_idx = 2'd0;
    cyc(1);
    ack = 1'b0;

    // Masked line still captures; unmask exposes it one cycle later.
    mask_we = 1'b1; mask_in = 4'b0111;
    cyc(1);
    mask_we = 1'b0;
    req = 4'b1000;
    cyc(1);
    req = '0;
    cyc(Lat - 1);
    chk("mask_raw", int'(raw_pending), 'b1000);
    chk("mask_pending", int'(pending), 'b0000);
    chk("mask_any", int'(any_pending), 0);
    mask_we = 1'b1; mask_in = 4'b1111;
    cyc(1);
    mask_we = 1'b0;
    chk("unmask_pending", int'(pending), 'b1000);

    // Two simultaneous drops count as two.
    pulse(4'b0100);
    pulse(4'b1100);
    cyc(Lat);
    chk("multi_drop_cnt", int'(drop_count), 5);

    // Saturation at 255.
    for (int k = 0; k < 260; k++) pulse(4'b0100);
    cyc(Lat);
    chk("sat_cnt", int'(drop_count), 255);
    pulse(4'b0100);
    cyc(Lat);
    chk("sat_hold", int'(drop_count), 255);

    // Mid-run reset discards everything.
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    chk("mrst_raw", int'(raw_pending), 'b0000);
    chk("mrst_pending", int'(pending), 'b0000);
    chk("mrst_any", int'(any_pending), 0);
    chk("mrst_drop", int'(drop_count), 0);
    cyc(2);

    // Exact latency on line 1; also shows the mask came back as all ones.
    req = 4'b0010;
    cyc(1);
    req = '0;
    if (Lat > 1) begin
      cyc(Lat - 2);
      chk("lat_early", int'(pending[1]), 0);
      cyc(1);
    end
    chk("lat_exact", int'(pending[1]), 1);
    chk("lat_any", int'(any_pending), 1);

    cyc(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
